// File: rtl/fnd_pkg.sv
// ============================================================================
// Module   : fnd_pkg
// Brief    : Shared FSM encoding, 7-segment patterns and select codes for cnt_to_fnd
// Revision : 1.0
// ============================================================================
`default_nettype none

package fnd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_LOAD = 2'd2
  } state_t;

  // Segment order is {g,f,e,d,c,b,a}, active-high
  localparam logic [6:0] SEG_0     = 7'b0111111;
  localparam logic [6:0] SEG_1     = 7'b0000110;
  localparam logic [6:0] SEG_2     = 7'b1011011;
  localparam logic [6:0] SEG_3     = 7'b1001111;
  localparam logic [6:0] SEG_4     = 7'b1100110;
  localparam logic [6:0] SEG_5     = 7'b1101101;
  localparam logic [6:0] SEG_6     = 7'b1111101;
  localparam logic [6:0] SEG_7     = 7'b0000111;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1101111;
  localparam logic [6:0] SEG_DASH  = 7'b1000000;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  localparam logic [1:0] DIGIT_ONES = 2'b10;
  localparam logic [1:0] DIGIT_TENS = 2'b01;

  localparam logic [6:0] CNT_MAX  = 7'd99;
  // Display-register code for the dash glyph; never a valid BCD digit
  localparam logic [3:0] DIG_DASH = 4'hA;

  function automatic logic [6:0] seg_decode(input logic [3:0] digit);
    logic [6:0] seg;
    case (digit)
      4'd0:     seg = SEG_0;
      4'd1:     seg = SEG_1;
      4'd2:     seg = SEG_2;
      4'd3:     seg = SEG_3;
      4'd4:     seg = SEG_4;
      4'd5:     seg = SEG_5;
      4'd6:     seg = SEG_6;
      4'd7:     seg = SEG_7;
      4'd8:     seg = SEG_8;
      4'd9:     seg = SEG_9;
      DIG_DASH: seg = SEG_DASH;
      default:  seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bin2bcd_seq.sv
// ============================================================================
// Module   : bin2bcd_seq
// Brief    : Sequential 7-bit double-dabble, one shift-add-3 iteration per cycle
// Revision : 1.0
// ============================================================================
`default_nettype none

module bin2bcd_seq
  import fnd_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic [6:0] bin,
  output logic       done,
  output logic [3:0] tens,
  output logic [3:0] ones
);

  localparam logic [2:0] C_LAST_ITER = 3'd6;

  // {tens[3:0], ones[3:0], bin[6:0]}
  logic [14:0] r_sr;
  logic [14:0] w_adj;
  logic [2:0]  r_iter;
  logic        r_run;

  always_comb begin
    w_adj = r_sr;
    if (r_sr[10:7] >= 4'd5)  w_adj[10:7]  = r_sr[10:7] + 4'd3;
    if (r_sr[14:11] >= 4'd5) w_adj[14:11] = r_sr[14:11] + 4'd3;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sr   <= '0;
      r_iter <= '0;
      r_run  <= 1'b0;
    end else if (start) begin
      r_sr   <= {8'd0, bin};
      r_iter <= '0;
      r_run  <= 1'b1;
    end else if (r_run) begin
      r_sr   <= {w_adj[13:0], 1'b0};
      r_iter <= r_iter + 3'd1;
      if (r_iter == C_LAST_ITER) r_run <= 1'b0;
    end
  end

  // Asserted during the final iteration so the caller can move on at that edge
  assign done = r_run && (r_iter == C_LAST_ITER);
  assign tens = r_sr[14:11];
  assign ones = r_sr[10:7];

endmodule

`default_nettype wire

// File: rtl/cnt_to_fnd.sv
// ============================================================================
// Module   : cnt_to_fnd
// Brief    : 0..99 count to 2-digit multiplexed 7-segment driver.
//            Optional macro FND_LZ_BLANK_EN blanks a leading zero in the tens digit.
// Revision : 1.0
// ============================================================================
`default_nettype none

module cnt_to_fnd
  import fnd_pkg::*;
#(
  parameter int unsigned P_REFRESH_DIV = 50000,
  parameter bit          P_SEG_ACT_LOW = 1'b0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [6:0] i_cnt,
  input  logic       i_valid,
  output logic       o_busy,
  output logic [6:0] o_seg,
  output logic [1:0] o_digit_sel
);

  localparam int unsigned     SCAN_W    = (P_REFRESH_DIV > 1) ? $clog2(P_REFRESH_DIV) : 1;
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(P_REFRESH_DIV - 1);
  localparam logic [6:0]      SEG_POL   = P_SEG_ACT_LOW ? 7'h7F : 7'h00;

  state_t      r_state, w_state_nxt;
  logic        w_start, w_load, w_done;
  logic [6:0]  w_start_val;
  logic        r_pend, r_ovr;
  logic [6:0]  r_pend_val;
  logic [3:0]  r_tens, r_ones, w_bcd_tens, w_bcd_ones;

  bin2bcd_seq u_bin2bcd (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (w_start),
    .bin     (w_start_val),
    .done    (w_done),
    .tens    (w_bcd_tens),
    .ones    (w_bcd_ones)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  // A fresh strobe in IDLE wins over the pending value: it is the newest
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_start_val = i_cnt;
    w_load      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_valid) begin
          w_start     = 1'b1;
          w_state_nxt = ST_CONV;
        end else if (r_pend) begin
          w_start     = 1'b1;
          w_start_val = r_pend_val;
          w_state_nxt = ST_CONV;
        end
      end
      ST_CONV: if (w_done) w_state_nxt = ST_LOAD;
      ST_LOAD: begin
        w_load      = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign o_busy = (r_state != ST_IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pend     <= 1'b0;
      r_pend_val <= '0;
      r_ovr      <= 1'b0;
      r_tens     <= '0;
      r_ones     <= '0;
    end else begin
      if (o_busy && i_valid) begin
        r_pend     <= 1'b1;
        r_pend_val <= i_cnt;
      end else if (w_start) begin
        r_pend     <= 1'b0;
      end
      if (w_start) r_ovr <= (w_start_val > CNT_MAX);
      if (w_load) begin
        r_tens <= r_ovr ? DIG_DASH : w_bcd_tens;
        r_ones <= r_ovr ? DIG_DASH : w_bcd_ones;
      end
    end
  end

  logic [SCAN_W-1:0] r_scan;
  logic              r_sel_tens, w_sel_tens_nxt, w_wrap, w_blank;
  logic [3:0]        w_digit;
  logic [6:0]        r_seg, w_seg_nxt;

  // Decode from the next active digit so o_seg and o_digit_sel switch together
  assign w_wrap         = (r_scan == SCAN_LAST);
  assign w_sel_tens_nxt = r_sel_tens ^ w_wrap;
  assign w_digit        = w_sel_tens_nxt ? r_tens : r_ones;

`ifdef FND_LZ_BLANK_EN
  assign w_blank = w_sel_tens_nxt && (r_tens == 4'd0);
`else
  assign w_blank = 1'b0;
`endif

  assign w_seg_nxt = (w_blank ? SEG_BLANK : seg_decode(w_digit)) ^ SEG_POL;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_scan     <= '0;
      r_sel_tens <= 1'b0;
      r_seg      <= SEG_0 ^ SEG_POL;
    end else begin
      r_scan     <= w_wrap ? '0 : r_scan + 1'b1;
      r_sel_tens <= w_sel_tens_nxt;
      r_seg      <= w_seg_nxt;
    end
  end

  assign o_seg       = r_seg;
  assign o_digit_sel = r_sel_tens ? DIGIT_TENS : DIGIT_ONES;

endmodule

`default_nettype wire

// File: tb/tb_cnt_to_fnd.sv
// ============================================================================
// Module   : tb_cnt_to_fnd
// Brief    : Directed self-checking bench for cnt_to_fnd (refresh divider 4)
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_cnt_to_fnd;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [6:0] i_cnt = 7'd0;
  logic       i_valid = 1'b0;
  logic       o_busy;
  logic [6:0] o_seg;
  logic [1:0] o_digit_sel;

  int checks = 0;
  int failures = 0;
  logic bad_sel = 1'b0;
  logic saw_tens3 = 1'b0;

`ifdef FND_LZ_BLANK_EN
  localparam logic [6:0] TENS_ZERO = 7'b0000000;
`else
  localparam logic [6:0] TENS_ZERO = 7'b0111111;
`endif

  always #5 clk = ~clk;

  cnt_to_fnd #(
    .P_REFRESH_DIV (4),
    .P_SEG_ACT_LOW (1'b0)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_cnt       (i_cnt),
    .i_valid     (i_valid),
    .o_busy      (o_busy),
    .o_seg       (o_seg),
    .o_digit_sel (o_digit_sel)
  );

  always @(negedge clk) begin
    if (reset_n && (o_digit_sel == 2'b00 || o_digit_sel == 2'b11)) bad_sel = 1'b1;
    if (o_digit_sel == 2'b01 && o_seg == 7'b1001111) saw_tens3 = 1'b1;
  end

  task automatic pulse(input logic [6:0] v);
    @(negedge clk);
    i_cnt   = v;
    i_valid = 1'b1;
    @(negedge clk);
    i_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (o_busy && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (o_busy !== 1'b0) begin
      failures++;
      $display("FAIL %s: busy still %b after %0d cycles, required 0", name, o_busy, n);
    end
  endtask

  // Waits for a fresh entry into the requested digit so o_seg reflects current display
  task automatic read_digit(input logic [1:0] want, output logic [6:0] seg);
    int n = 0;
    while (o_digit_sel == want && n < 20) begin @(negedge clk); n++; end
    while (o_digit_sel != want && n < 20) begin @(negedge clk); n++; end
    seg = o_seg;
    if (n >= 20) begin
      checks++;
      failures++;
      $display("FAIL read_digit timeout: sel %b, required %b", o_digit_sel, want);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #100;
    reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if (o_digit_sel !== 2'b10) begin failures++; $display("FAIL reset_sel: got %b, required 10", o_digit_sel); end
    checks++;
    if (o_seg !== 7'b0111111) begin failures++; $display("FAIL reset_seg: got %b, required 0111111", o_seg); end
    checks++;
    if (o_busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b, required 0", o_busy); end
  endtask

  task automatic test_conversion();
    int n = 0;
    logic [6:0] s;
    pulse(7'd57);
    while (o_busy && n < 20) begin n++; @(negedge clk); end
    checks++;
    if (n != 8) begin failures++; $display("FAIL conv_busy_len: got %0d, required 8", n); end
    read_digit(2'b01, s);
    checks++;
    if (s !== 7'b1101101) begin failures++; $display("FAIL conv_tens: got %b, required 1101101", s); end
    read_digit(2'b10, s);
    checks++;
    if (s !== 7'b0000111) begin failures++; $display("FAIL conv_ones: got %b, required 0000111", s); end
  endtask

  task automatic test_back_to_back();
    logic [6:0] t_seg = 7'd0, o_sg = 7'd0, s;
    logic seen_busy = 1'b0;
    int n = 0;
    saw_tens3 = 1'b0;
    pulse(7'd12);
    i_cnt   = 7'd34;
    i_valid = 1'b1;
    @(negedge clk);
    i_cnt = 7'd99;
    @(negedge clk);
    i_valid = 1'b0;
    wait_idle("b2b_first");
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      if (o_digit_sel == 2'b01) t_seg = o_seg;
      if (o_digit_sel == 2'b10) o_sg  = o_seg;
      seen_busy |= o_busy;
      @(negedge clk);
    end
    checks++;
    if (t_seg !== 7'b0000110) begin failures++; $display("FAIL b2b_first_tens: got %b, required 0000110", t_seg); end
    checks++;
    if (o_sg !== 7'b1011011) begin failures++; $display("FAIL b2b_first_ones: got %b, required 1011011", o_sg); end
    checks++;
    if (seen_busy !== 1'b1) begin failures++; $display("FAIL b2b_pending_start: busy seen %b, required 1", seen_busy); end
    wait_idle("b2b_second");
    read_digit(2'b01, s);
    checks++;
    if (s !== 7'b1101111) begin failures++; $display("FAIL b2b_last_tens: got %b, required 1101111", s); end
    read_digit(2'b10, s);
    checks++;
    if (s !== 7'b1101111) begin failures++; $display("FAIL b2b_last_ones: got %b, required 1101111", s); end
    seen_busy = 1'b0;
    for (n = 0; n < 12; n++) begin seen_busy |= o_busy; @(negedge clk); end
    checks++;
    if (seen_busy !== 1'b0) begin failures++; $display("FAIL b2b_extra_conv: busy seen %b, required 0", seen_busy); end
    checks++;
    if (saw_tens3 !== 1'b0) begin failures++; $display("FAIL b2b_34_shown: tens 3 seen %b, required 0", saw_tens3); end
  endtask

  task automatic test_scan_wrap();
    logic [1:0] prev;
    logic [6:0] s;
    int n;
    for (int k = 0; k < 2; k++) begin
      n = 0;
      prev = o_digit_sel;
      while (o_digit_sel == prev && n < 10) begin @(negedge clk); n++; end
      n = 0;
      prev = o_digit_sel;
      while (o_digit_sel == prev && n < 10) begin @(negedge clk); n++; end
      checks++;
      if (n != 4) begin failures++; $display("FAIL scan_period: got %0d cycles, required 4", n); end
    end
    checks++;
    if (bad_sel !== 1'b0) begin failures++; $display("FAIL scan_illegal_sel: flag %b, required 0", bad_sel); end
    pulse(7'd98);
    wait_idle("scan_98");
    read_digit(2'b10, s);
    checks++;
    if (s !== 7'b1111111) begin failures++; $display("FAIL scan_98_ones: got %b, required 1111111", s); end
    pulse(7'd99);
    wait_idle("scan_99");
    read_digit(2'b10, s);
    checks++;
    if (s !== 7'b1101111) begin failures++; $display("FAIL scan_99_ones: got %b, required 1101111", s); end
    pulse(7'd0);
    wait_idle("scan_0");
    read_digit(2'b01, s);
    checks++;
    if (s !== TENS_ZERO) begin failures++; $display("FAIL scan_0_tens: got %b, required %b", s, TENS_ZERO); end
    read_digit(2'b10, s);
    checks++;
    if (s !== 7'b0111111) begin failures++; $display("FAIL scan_0_ones: got %b, required 0111111", s); end
  endtask

  task automatic test_out_of_range();
    logic [6:0] s;
    pulse(7'd100);
    wait_idle("oor");
    read_digit(2'b01, s);
    checks++;
    if (s !== 7'b1000000) begin failures++; $display("FAIL oor_tens: got %b, required 1000000", s); end
    read_digit(2'b10, s);
    checks++;
    if (s !== 7'b1000000) begin failures++; $display("FAIL oor_ones: got %b, required 1000000", s); end
  endtask

  task automatic test_lz_blank();
    logic [6:0] s;
    pulse(7'd5);
    wait_idle("lz");
    read_digit(2'b01, s);
    checks++;
    if (s !== TENS_ZERO) begin failures++; $display("FAIL lz_tens: got %b, required %b", s, TENS_ZERO); end
    read_digit(2'b10, s);
    checks++;
    if (s !== 7'b1101101) begin failures++; $display("FAIL lz_ones: got %b, required 1101101", s); end
  endtask

  task automatic test_reset_mid_conv();
    logic [6:0] s;
    logic seen_busy = 1'b0;
    pulse(7'd57);
    pulse(7'd23);
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    checks++;
    if (o_busy !== 1'b0) begin failures++; $display("FAIL rst_mid_busy: got %b, required 0", o_busy); end
    reset_n = 1'b1;
    for (int i = 0; i < 12; i++) begin seen_busy |= o_busy; @(negedge clk); end
    checks++;
    if (seen_busy !== 1'b0) begin failures++; $display("FAIL rst_mid_pending: busy seen %b, required 0", seen_busy); end
    read_digit(2'b10, s);
    checks++;
    if (s !== 7'b0111111) begin failures++; $display("FAIL rst_mid_ones: got %b, required 0111111", s); end
    read_digit(2'b01, s);
    checks++;
    if (s !== TENS_ZERO) begin failures++; $display("FAIL rst_mid_tens: got %b, required %b", s, TENS_ZERO); end
  endtask

  initial begin
    test_reset();
    test_conversion();
    test_back_to_back();
    test_scan_wrap();
    test_out_of_range();
    test_lz_blank();
    test_reset_mid_conv();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
